// File: rtl/mult_pkg.sv
// Shared constants for the shared-multiplier arbiter: datapath widths and
// FSM state encoding used by the top and its interface.
package mult_pkg;
    localparam int MULT_W = 32;
    localparam int PROD_W = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bundle of request lanes and the single tagged response port.
// master = requester/consumer side, slave = the arbiter.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import mult_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*MULT_W-1:0] req_a;
    logic [N_REQ*MULT_W-1:0] req_b;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [PROD_W-1:0]       rsp_p;
    logic                    rsp_ready;
    logic [15:0]             ops_done;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, ops_done
    );
endinterface

// File: rtl/booth_radix4_multiplier_32.sv
// Combinational 32x32 signed radix-4 Booth multiplier. Sixteen Booth digits
// each select 0, +-A or +-2A; the shifted partial products are summed into a
// full 64-bit product. The partial products are also exported for debug.
module booth_radix4_multiplier_32 (
    input  logic signed [31:0]   a,
    input  logic signed [31:0]   b,
    output logic signed [63:0]   p,
    output logic [16*64-1:0]     pp
);
    logic [32:0]        b_ext;
    logic signed [63:0] a_ext;
    logic signed [63:0] pp_arr [16];

    assign b_ext = {b, 1'b0};
    assign a_ext = {{32{a[31]}}, a};

    for (genvar gi = 0; gi < 16; gi++) begin : g_pp
        logic [2:0]         sel;
        logic signed [63:0] mag;

        assign sel = b_ext[2*gi+2 : 2*gi];

        // Booth digit decode: overlapping triplet selects the multiple of A
        always_comb begin
            case (sel)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext <<< 1;
                3'b100:         mag = -(a_ext <<< 1);
                3'b101, 3'b110: mag = -a_ext;
                default:        mag = '0;
            endcase
        end

        assign pp_arr[gi]       = mag <<< (2*gi);
        assign pp[gi*64 +: 64]  = pp_arr[gi];
    end

    // Sum of all weighted partial products (wraps naturally at 64 bits)
    always_comb begin
        p = '0;
        for (int k = 0; k < 16; k++) begin
            p = p + pp_arr[k];
        end
    end
endmodule

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first valid lane at or above ptr wins,
// otherwise the search wraps to the lowest valid lane.
module mult_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    logic [N_REQ-1:0] upper_valid;
    logic [N_REQ-1:0] search_vec;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign upper_valid[gi] = valid[gi] && (ID_W'(gi) >= ptr);
    end

    // Lanes at/after the pointer take priority; fall back to the wrapped set
    assign search_vec = (|upper_valid) ? upper_valid : valid;
    assign any        = |valid;

    // Lowest set bit of the search vector becomes the one-hot grant
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (search_vec[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one Booth multiplier among N_REQ requesters. Round-robin grant,
// registered operands, one CALC cycle, then a tagged response held until
// the consumer takes it. A new request may be accepted in the same cycle a
// response completes, giving one result every two cycles.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus
);
    logic [1:0]              state_reg;
    logic [MULT_W-1:0]       op_a_reg;
    logic [MULT_W-1:0]       op_b_reg;
    logic [ID_W-1:0]         op_id_reg;
    logic [PROD_W-1:0]       rsp_p_reg;
    logic [ID_W-1:0]         rsp_id_reg;
    logic [ID_W-1:0]         rr_ptr_reg;
    logic [15:0]             ops_done_reg;

    logic [N_REQ-1:0]        pick_grant;
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;
    logic                    accept_window;
    logic                    accept;
    logic [ID_W-1:0]         rr_ptr_next;
    logic signed [PROD_W-1:0] product;
    logic [MULT_W-1:0]       lane_a [N_REQ];
    logic [MULT_W-1:0]       lane_b [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign lane_a[gi] = bus.req_a[gi*MULT_W +: MULT_W];
        assign lane_b[gi] = bus.req_b[gi*MULT_W +: MULT_W];
    end

    mult_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    booth_radix4_multiplier_32 u_mult (
        .a  (op_a_reg),
        .b  (op_b_reg),
        .p  (product),
        .pp ()
    );

    // Accept while idle, or while the pending response is being taken.
    // Reset masks the grant so nothing appears accepted while held in reset.
    assign accept_window = !rst && ((state_reg == IDLE) ||
                                    ((state_reg == RESP) && bus.rsp_ready));
    assign accept        = accept_window && pick_any;
    assign rr_ptr_next   = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    assign bus.req_ready = accept_window ? pick_grant : '0;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_p     = rsp_p_reg;
    assign bus.ops_done  = ops_done_reg;

    // Operand capture, product capture and FSM sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_id_reg    <= '0;
            rsp_p_reg    <= '0;
            rsp_id_reg   <= '0;
            rr_ptr_reg   <= '0;
            ops_done_reg <= '0;
        end else begin
            if (accept) begin
                op_a_reg   <= lane_a[pick_idx];
                op_b_reg   <= lane_b[pick_idx];
                op_id_reg  <= pick_idx;
                rr_ptr_reg <= rr_ptr_next;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    rsp_p_reg  <= product;
                    rsp_id_reg <= op_id_reg;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        ops_done_reg <= ops_done_reg + 16'd1;
                        state_reg    <= accept ? CALC : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for the shared Booth multiplier arbiter.
module tb_mult_share_arbiter;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mult_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    mult_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on a lane and wait for its response (rsp_ready high).
    // lat = sample points from the accepting cycle to the first rsp_valid, -1 on timeout.
    task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output logic [1:0] id, output int lat);
        int n;
        lat = -1;
        p   = '0;
        id  = '0;
        bus.req_a[lane*32 +: 32] = a;
        bus.req_b[lane*32 +: 32] = b;
        bus.req_valid[lane] = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[lane] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (bus.req_ready[lane]) begin
            @(negedge clk);
            bus.req_valid[lane] = 1'b0;
            #1;
            n = 1;
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk); #1; n++;
            end
            if (bus.rsp_valid) begin
                lat = n;
                p   = bus.rsp_p;
                id  = bus.rsp_id;
            end
        end else begin
            bus.req_valid[lane] = 1'b0;
        end
        $display("op lane=%0d a=%0d b=%0d p=%h id=%0d lat=%0d",
                 lane, $signed(a), $signed(b), p, id, lat);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_p !== 64'd0) begin errors++; $display("FAIL reset_rsp_p: got %h expected 0", bus.rsp_p); end
        checks++; if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done: got %0d expected 0", bus.ops_done); end
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [63:0] p; logic [1:0] id; int lat;
        run_op(0, 32'd15, 32'd3, p, id, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
        checks++; if (p !== 64'd45) begin errors++; $display("FAIL single_p: got %h expected %h", p, 64'd45); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", id); end
        #1;
        checks++; if (bus.ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done: got %0d expected 1", bus.ops_done); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_signed();
        logic [63:0] p; logic [1:0] id; int lat;
        logic [63:0] exp_p [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        va[0] = -32'sd25;    vb[0] = 32'sd12;     exp_p[0] = 64'hFFFF_FFFF_FFFF_FED4;
        va[1] = 32'sd12345;  vb[1] = -32'sd6789;  exp_p[1] = -64'sd83810205;
        va[2] = -32'sd1024;  vb[2] = -32'sd2048;  exp_p[2] = 64'sd2097152;
        for (int i = 0; i < 3; i++) begin
            run_op(i + 1, va[i], vb[i], p, id, lat);
            checks++; if (p !== exp_p[i]) begin errors++; $display("FAIL signed_p%0d: got %h expected %h", i + 1, p, exp_p[i]); end
            checks++; if (id !== 2'(i + 1)) begin errors++; $display("FAIL signed_id%0d: got %0d expected %0d", i + 1, id, i + 1); end
        end
    endtask

    task automatic test_fairness();
        int grants[$];
        int rids[$];
        logic [63:0] rps[$];
        int rcyc[$];
        int cyc;
        logic [15:0] done0;
        done0 = bus.ops_done;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'(i + 1);
            bus.req_b[i*32 +: 32] = 32'd100;
        end
        bus.req_valid = 4'hF;
        cyc = 0;
        while (cyc < 60) begin
            #1;
            if ((bus.req_valid & bus.req_ready) != 4'b0 && grants.size() < 8) begin
                for (int k = 0; k < 4; k++) if (bus.req_ready[k]) grants.push_back(k);
            end
            if (bus.rsp_valid) begin
                rids.push_back(int'(bus.rsp_id));
                rps.push_back(bus.rsp_p);
                rcyc.push_back(cyc);
                $display("fair rsp id=%0d p=%0d cyc=%0d", bus.rsp_id, bus.rsp_p, cyc);
            end
            if (rids.size() == 8) begin
                bus.req_valid = '0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checks++; if (rids.size() !== 8) begin errors++; $display("FAIL fair_count: got %0d expected 8", rids.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            checks++; if (grants[i] !== (i % 4)) begin errors++; $display("FAIL fair_grant%0d: got %0d expected %0d", i, grants[i], i % 4); end
        end
        for (int i = 0; i < rids.size(); i++) begin
            checks++; if (rids[i] !== (i % 4)) begin errors++; $display("FAIL fair_id%0d: got %0d expected %0d", i, rids[i], i % 4); end
            checks++; if (rps[i] !== 64'((i % 4 + 1) * 100)) begin errors++; $display("FAIL fair_p%0d: got %0d expected %0d", i, rps[i], (i % 4 + 1) * 100); end
            if (i > 0) begin
                checks++; if (rcyc[i] - rcyc[i-1] !== 2) begin errors++; $display("FAIL fair_spacing%0d: got %0d expected 2", i, rcyc[i] - rcyc[i-1]); end
            end
        end
        #1;
        checks++; if (bus.ops_done !== done0 + 16'd8) begin errors++; $display("FAIL fair_ops_done: got %0d expected %0d", bus.ops_done, done0 + 16'd8); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] done0;
        bus.rsp_ready = 1'b0;
        bus.req_a[2*32 +: 32] = 32'sd7;
        bus.req_b[2*32 +: 32] = -32'sd6;
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        bus.req_a[1*32 +: 32] = 32'd1;
        bus.req_b[1*32 +: 32] = 32'd1;
        bus.req_valid = 4'b0010;
        #1;
        done0 = bus.ops_done;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_p !== -64'sd42) begin errors++; $display("FAIL bp_p: got %h expected %h", bus.rsp_p, -64'sd42); end
        checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id: got %0d expected 2", bus.rsp_id); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== -64'sd42 || bus.rsp_id !== 2'd2)
                begin errors++; $display("FAIL bp_hold%0d: got v=%b p=%h id=%0d expected v=1 p=%h id=2", i, bus.rsp_valid, bus.rsp_p, bus.rsp_id, -64'sd42); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready%0d: got %b expected 0000", i, bus.req_ready); end
            checks++; if (bus.ops_done !== done0) begin errors++; $display("FAIL bp_ops_hold%0d: got %0d expected %0d", i, bus.ops_done, done0); end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.ops_done !== done0 + 16'd1) begin errors++; $display("FAIL bp_release_ops: got %0d expected %0d", bus.ops_done, done0 + 16'd1); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", bus.rsp_valid); end
        @(negedge clk); #1;
        checks++; if (bus.ops_done !== done0 + 16'd1) begin errors++; $display("FAIL bp_once: got %0d expected %0d", bus.ops_done, done0 + 16'd1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        bus.rsp_ready = 1'b1;
        bus.req_a[1*32 +: 32] = 32'd5;
        bus.req_b[1*32 +: 32] = 32'd9;
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst_pre_grant: got %b expected 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_p !== 64'd0 || bus.rsp_id !== 2'd0 || bus.ops_done !== 16'd0 || bus.req_ready !== 4'b0)
            begin errors++; $display("FAIL rst_async: got v=%b p=%h id=%0d done=%0d rdy=%b expected all 0", bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.ops_done, bus.req_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp%0d: got %b expected 0", i, bus.rsp_valid); end
            @(negedge clk);
        end
        bus.req_a[0*32 +: 32] = 32'd6;
        bus.req_b[0*32 +: 32] = 32'd7;
        bus.req_a[3*32 +: 32] = 32'd2;
        bus.req_b[3*32 +: 32] = 32'd2;
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 64'd42 || bus.rsp_id !== 2'd0)
            begin errors++; $display("FAIL rst_after_rsp: got v=%b p=%h id=%0d expected v=1 p=2a id=0", bus.rsp_valid, bus.rsp_p, bus.rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_edge_arith();
        logic [63:0] p; logic [1:0] id; int lat;
        run_op(0, 32'h8000_0000, 32'h8000_0000, p, id, lat);
        checks++; if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL edge_minmin: got %h expected 4000000000000000", p); end
        run_op(2, 32'd0, 32'hFFFF_FFFF, p, id, lat);
        checks++; if (p !== 64'd0) begin errors++; $display("FAIL edge_zero: got %h expected 0", p); end
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL edge_zero_id: got %0d expected 2", id); end
        run_op(3, 32'h7FFF_FFFF, 32'h8000_0000, p, id, lat);
        checks++; if (p !== 64'hC000_0000_8000_0000) begin errors++; $display("FAIL edge_maxmin: got %h expected c000000080000000", p); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_signed();
        test_fairness();
        test_backpressure();
        test_reset_mid_calc();
        test_edge_arith();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
